// File: rtl/rng_pkg.sv
// Shared definitions for the RNG source and its die-roll post-processor:
// FSM state encoding and the default random word width.
package rng_pkg;

  localparam int RNG_DATA_W_DEF = 7;
  localparam int RNG_DIV_W      = 8;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_COLLECT_ENC = 2'd1;
  localparam logic [1:0] ST_VALID_ENC   = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE_ENC,
    COLLECT = ST_COLLECT_ENC,
    VALID   = ST_VALID_ENC
  } rng_state_t;

endpackage

// File: rtl/rng_source_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rng_source.sv
// Entropy collector: samples a synchronized oscillator bit every SAMPLE_DIV
// cycles and assembles DATA_W accepted bits into a word (first bit ends in
// the MSB). The consumer drives i_stop low to request a word and high to
// release it or abort a collection.
// Optional macro RNG_VON_NEUMANN_EN: strobes are taken in pairs and debiased
// (10 -> 1, 01 -> 0, 00/11 dropped).
module rng_source
  import rng_pkg::*;
#(
  parameter int DATA_W     = RNG_DATA_W_DEF,
  parameter int SAMPLE_DIV = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_stop,
  input  logic              i_entropy,
  output logic [DATA_W-1:0] o_randomData,
  output logic              o_valid
);

  localparam int                   CNT_W    = $clog2(DATA_W + 1);
  localparam logic [RNG_DIV_W-1:0] DIV_LAST = RNG_DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_W - 1);

  rng_state_t           r_state;
  rng_state_t           w_state_nxt;
  logic                 w_sync;
  logic [RNG_DIV_W-1:0] r_div;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_W-2:0]    r_shift;
  logic [DATA_W-1:0]    r_data;
  logic                 r_valid;
  logic                 w_strobe;
  logic                 w_accept;
  logic                 w_take;
  logic                 w_bit;
  logic                 w_last;
  logic [DATA_W-1:0]    w_word;

  sync_2ff u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_entropy),
    .o_q       (w_sync)
  );

  // One strobe per SAMPLE_DIV cycles, counted from COLLECT entry.
  assign w_strobe = (r_state == COLLECT) && (r_div == DIV_LAST);

`ifdef RNG_VON_NEUMANN_EN
  logic r_phase;
  logic r_first;

  // Pair tracker: phase 0 captures the first bit, phase 1 completes the pair.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_phase <= 1'b0;
      r_first <= 1'b0;
    end else if (r_state != COLLECT) begin
      r_phase <= 1'b0;
      r_first <= 1'b0;
    end else if (w_strobe && !i_stop) begin
      r_phase <= ~r_phase;
      if (!r_phase) begin
        r_first <= w_sync;
      end
    end
  end

  // Unequal pair yields its first bit; equal pairs carry no information.
  assign w_accept = w_strobe && r_phase && (r_first != w_sync);
  assign w_bit    = r_first;
`else
  assign w_accept = w_strobe;
  assign w_bit    = w_sync;
`endif

  // An abort in the same cycle as a strobe wins: nothing is accepted.
  assign w_take = w_accept && !i_stop;
  assign w_last = w_take && (r_cnt == CNT_LAST);
  assign w_word = {r_shift, w_bit};

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; i_stop has priority over word completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!i_stop) begin
          w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (i_stop) begin
          w_state_nxt = IDLE;
        end else if (w_last) begin
          w_state_nxt = VALID;
        end
      end
      VALID: begin
        if (i_stop) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sample divider: free-runs only in COLLECT, held at zero otherwise.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div <= '0;
    end else if (r_state != COLLECT) begin
      r_div <= '0;
    end else if (w_strobe) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + RNG_DIV_W'(1);
    end
  end

  // Bit count and partial word; any exit from COLLECT discards them.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (r_state != COLLECT) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_take) begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_shift <= w_word[DATA_W-2:0];
    end
  end

  // Output word loads only on completion, so it stays frozen while valid
  // and keeps its last value after release or abort.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (w_state_nxt == VALID);
      if (w_last) begin
        r_data <= w_word;
      end
    end
  end

  assign o_randomData = r_data;
  assign o_valid      = r_valid;

endmodule

// File: tb/tb_rng_source.sv
// Bench for rng_source: one SAMPLE_DIV=1 instance and one SAMPLE_DIV=4
// instance sharing clock and reset. Expected words come from a bit-stream
// model and are queued when stimulus starts, popped when o_valid is seen.
module tb_rng_source;
  import rng_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stop1, ent1, stop4, ent4;
  logic [6:0] data1, data4;
  logic       valid1, valid4;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  rng_source #(.DATA_W(7), .SAMPLE_DIV(1)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_stop(stop1), .i_entropy(ent1),
    .o_randomData(data1), .o_valid(valid1)
  );

  rng_source #(.DATA_W(7), .SAMPLE_DIV(4)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_stop(stop4), .i_entropy(ent4),
    .o_randomData(data4), .o_valid(valid4)
  );

  task automatic drive(input int sel, input logic s, input logic e);
    if (sel == 0) begin
      stop1 = s;
      ent1  = e;
    end else begin
      stop4 = s;
      ent4  = e;
    end
  endtask

  function automatic logic rd_valid(input int sel);
    return (sel == 0) ? valid1 : valid4;
  endfunction

  function automatic logic [6:0] rd_data(input int sel);
    return (sel == 0) ? data1 : data4;
  endfunction

  // Reference: word assembled from the bit stream (MSB-first in seq) and
  // the strobe number on which the 7th bit is accepted.
  function automatic void model(input logic [63:0] seq, input int n,
                                output logic [6:0] w, output int done);
    int cnt;
    w = '0;
    done = 0;
    cnt = 0;
`ifdef RNG_VON_NEUMANN_EN
    for (int i = 0; i + 1 < n && cnt < 7; i += 2) begin
      if (seq[n-1-i] != seq[n-2-i]) begin
        w = {w[5:0], seq[n-1-i]};
        cnt++;
        if (cnt == 7) done = i + 2;
      end
    end
`else
    for (int i = 0; i < n && cnt < 7; i++) begin
      w = {w[5:0], seq[n-1-i]};
      cnt++;
      if (cnt == 7) done = i + 1;
    end
`endif
  endfunction

  function automatic logic consumer_rejects(input logic [6:0] v);
    return (v == 7'd0) || (v > 7'd120);
  endfunction

  // Requests one word: i_stop high for one cycle, then low. The entropy
  // stream is aligned so strobe k sees seq bit k-1 through the synchronizer.
  // o_valid must rise exactly div*done edges after the falling i_stop is
  // sampled, plus the sampling edge itself.
  task automatic run_word(input int sel, input int div, input logic [63:0] seq,
                          input int n, input string name);
    logic [6:0] expw;
    logic [6:0] got;
    int done, lat, idx;
    logic early;
    model(seq, n, expw, done);
    lat = div * done;
    exp_q.push_back(expw);
    early = 1'b0;
    for (int m = -1; m <= lat; m++) begin
      idx = (m + 2 + div - 1) / div - 1;
      if (idx > n - 1) idx = n - 1;
      @(negedge clk);
      drive(sel, (m < 0), seq[n-1-idx]);
      @(posedge clk);
      #1;
      if (m < lat && rd_valid(sel) !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL %s_early valid=1 before word complete, required 0", name);
    end
    checks++;
    if (rd_valid(sel) !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency valid=%b after %0d edges, required 1", name, rd_valid(sel), lat + 1);
      void'(exp_q.pop_front());
    end else begin
      got = rd_data(sel);
      expw = exp_q.pop_front();
      checks++;
      if (got !== expw) begin
        errors++;
        $display("FAIL %s_data got=%h required=%h", name, got, expw);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0);
    drive(1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid1 got=%b required=0", valid1); end
    checks++; if (data1 !== 7'h00) begin errors++; $display("FAIL reset_data1 got=%h required=00", data1); end
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid4 got=%b required=0", valid4); end
    checks++; if (data4 !== 7'h00) begin errors++; $display("FAIL reset_data4 got=%h required=00", data4); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%b required=0", valid1); end
  endtask

  task automatic test_divider();
    run_word(1, 4, 64'b1111111, 7, "divider");
    @(negedge clk);
    drive(1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL divider_release valid=%b required=0", valid4); end
  endtask

  task automatic test_basic();
    logic held;
    run_word(0, 1, 64'b1011001, 7, "basic");
    held = 1'b1;
    repeat (5) begin
      @(negedge clk);
      drive(0, 1'b0, $urandom_range(1));
      @(posedge clk);
      #1;
      if (valid1 !== 1'b1 || data1 !== 7'h59) held = 1'b0;
    end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL basic_hold valid=%b data=%h required 1/59", valid1, data1); end
    @(negedge clk);
    drive(0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL basic_fall valid=%b required=0", valid1); end
    checks++; if (data1 !== 7'h59) begin errors++; $display("FAIL basic_retain data=%h required=59", data1); end
  endtask

  task automatic test_abort();
    logic low;
    // Four strobes accept four 1s, then i_stop rises before the fifth.
    for (int m = -1; m <= 4; m++) begin
      @(negedge clk);
      drive(0, (m < 0), 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    drive(0, 1'b1, 1'b1);
    low = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (valid1 !== 1'b0) low = 1'b0;
    end
    checks++; if (low !== 1'b1) begin errors++; $display("FAIL abort_valid valid rose, required 0"); end
    checks++; if (data1 !== 7'h59) begin errors++; $display("FAIL abort_retain data=%h required=59", data1); end
    run_word(0, 1, 64'b0000000, 7, "abort_next");
  endtask

  task automatic test_consumer();
    checks++;
    if (!(valid1 === 1'b1 && consumer_rejects(data1))) begin
      errors++;
      $display("FAIL consumer_reject valid=%b data=%h required 1/00", valid1, data1);
    end
    run_word(0, 1, 64'b0101010, 7, "consumer_retry");
    checks++;
    if (consumer_rejects(data1) !== 1'b0) begin
      errors++;
      $display("FAIL consumer_accept data=%h required in 1..120", data1);
    end
  endtask

  task automatic test_async_reset();
    logic low;
    for (int m = -1; m <= 3; m++) begin
      @(negedge clk);
      drive(0, (m < 0), 1'b1);
      @(posedge clk);
    end
    #3;
    rst_n = 1'b0;
    stop1 = 1'b1;
    #1;
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL areset_valid1 got=%b required=0", valid1); end
    checks++; if (data1 !== 7'h00) begin errors++; $display("FAIL areset_data1 got=%h required=00", data1); end
    checks++; if (data4 !== 7'h00) begin errors++; $display("FAIL areset_data4 got=%h required=00", data4); end
    @(negedge clk);
    rst_n = 1'b1;
    low = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (valid1 !== 1'b0 || data1 !== 7'h00) low = 1'b0;
    end
    checks++; if (low !== 1'b1) begin errors++; $display("FAIL areset_hold valid=%b data=%h required 0/00", valid1, data1); end
    run_word(0, 1, 64'b1011001, 7, "areset_recover");
  endtask

  task automatic test_whitening();
    run_word(0, 1, 64'b100001111010010110, 18, "whiten");
    checks++; if (data1 !== 7'h59) begin errors++; $display("FAIL whiten_const data=%h required=59", data1); end
    run_word(0, 1, 64'b11100100011001100110, 20, "whiten2");
  endtask

  initial begin
    rst_n = 1'b0;
    stop1 = 1'b1; ent1 = 1'b0;
    stop4 = 1'b1; ent4 = 1'b0;
    test_reset();
`ifdef RNG_VON_NEUMANN_EN
    test_whitening();
`else
    test_divider();
    test_basic();
    test_abort();
    test_consumer();
    test_async_reset();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
